// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-stage PC controller.
// Address map and redirect-tracking FSM encoding.
package fetch_pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC register with next-PC selection, stall-safe redirect capture
// and fetch address error detection.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pc_ctrl_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = fetch_pc_ctrl_pkg::EXC_PC,
  parameter logic [31:0] TEXT_LO  = fetch_pc_ctrl_pkg::TEXT_LO,
  parameter logic [31:0] TEXT_HI  = fetch_pc_ctrl_pkg::TEXT_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic [31:0] pc_next,
  output logic        flush_f,
  output logic        adel_f
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  logic [31:0]  pc_r;
  logic [31:0]  pend_tgt_r;
  logic [31:0]  pend_tgt_next_s;
  logic [31:0]  pc_next_s;

  // State register: PC, FSM state and the captured redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      state_r    <= RUN;
      pend_tgt_r <= 32'h0000_0000;
    end else begin
      pc_r       <= pc_next_s;
      state_r    <= state_next_s;
      pend_tgt_r <= pend_tgt_next_s;
    end
  end

  // Next-state logic: prioritised next-PC selection and redirect capture.
  always_comb begin
    pc_next_s       = pc_r + 32'd4;
    state_next_s    = state_r;
    pend_tgt_next_s = pend_tgt_r;
    if (reset) begin
      pc_next_s       = RESET_PC;
      state_next_s    = RUN;
      pend_tgt_next_s = 32'h0000_0000;
    end else if (exc_req) begin
      pc_next_s       = EXC_PC;
      state_next_s    = RUN;
      pend_tgt_next_s = 32'h0000_0000;
    end else if (eret_req) begin
      pc_next_s       = epc;
      state_next_s    = RUN;
      pend_tgt_next_s = 32'h0000_0000;
    end else if (stall) begin
      // A redirect seen during a stall is parked until the stall releases.
      pc_next_s = pc_r;
      if (br_valid) begin
        pend_tgt_next_s = br_target;
        state_next_s    = PEND;
      end else begin
        state_next_s = state_r;
      end
    end else begin
      case (state_r)
        PEND: begin
          pc_next_s    = pend_tgt_r;
          state_next_s = RUN;
        end
        RUN: begin
          if (br_valid) begin
            pc_next_s = br_target;
          end else begin
            pc_next_s = pc_r + 32'd4;
          end
          state_next_s = RUN;
        end
        default: begin
          pc_next_s    = RESET_PC;
          state_next_s = RUN;
        end
      endcase
    end
  end

  // Output logic: PC views, IF flush request and fetch address error.
  always_comb begin
    pc_f    = pc_r;
    pc_next = pc_next_s;
    flush_f = exc_req | eret_req;
    adel_f  = (pc_r[1:0] != 2'b00) | (pc_r < TEXT_LO) | (pc_r > TEXT_HI);
  end

endmodule
